vga_sync_gen: RTL and testbench

//   Upstream raster timing stage for the on-screen overlay/animation layers: it

---
 rtl/vga_sync_gen_if.sv | 24 ++
 rtl/vga_sync_gen.sv | 121 ++++++++++++
 tb/tb_vga_sync_gen.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle shared between the sync generator and its consumers.
//   pix_x, pix_y : current column / line (10 bits)
//   video_on     : 1 inside the visible window
//   hsync, vsync : monitor sync pulses
//   p_tick       : one-clk pixel strobe
//   frame_tick   : one-clk strobe on the last pixel of a frame
// The generator drives through the master modport, consumers read through slave.
interface vga_sync_gen_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       p_tick;
    logic       frame_tick;

    modport master (
        output pix_x, pix_y, video_on, hsync, vsync, p_tick, frame_tick
    );

    modport slave (
        input pix_x, pix_y, video_on, hsync, vsync, p_tick, frame_tick
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: a clock prescaler produces the pixel strobe, and
// horizontal/vertical counters walk the full raster (visible + porches + sync).
// Decoded outputs are registered from the next counter values so they change on
// the same edge as the coordinates.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   vga   : vga_sync_gen_if master (pix_x, pix_y, video_on, hsync, vsync,
//           p_tick, frame_tick)
module vga_sync_gen #(
    parameter int DIV      = 4,
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || DIV < 1) begin : g_param_check
            $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024 and DIV >= 1");
        end
    endgenerate

    logic [PW-1:0] presc_p0;
    logic          tick_p0;
    logic [9:0]    x_p0;
    logic [9:0]    y_p0;
    logic          von_p0;
    logic          hs_p0;
    logic          vs_p0;
    logic          ft_p0;

    logic [PW-1:0] presc_next;
    logic          tick_next;
    logic [9:0]    x_next;
    logic [9:0]    y_next;
    logic          von_next;
    logic          hs_next;
    logic          vs_next;
    logic          ft_next;

    always_comb begin
        presc_next = (presc_p0 == PRE_MAX) ? '0 : presc_p0 + 1'b1;
        // p_tick is registered, so it is decoded from the prescaler's next value
        // to line up with the cycle in which the prescaler sits at DIV-1.
        tick_next  = (presc_next == PRE_MAX);

        x_next = x_p0;
        y_next = y_p0;
        if (tick_p0) begin
            if (x_p0 == H_MAX) begin
                x_next = '0;
                y_next = (y_p0 == V_MAX) ? '0 : y_p0 + 10'd1;
            end else begin
                x_next = x_p0 + 10'd1;
            end
        end

        // Decoding from the next coordinates keeps these aligned with pix_x/pix_y
        // rather than one cycle behind.
        von_next = (x_next < H_VIS) && (y_next < V_VIS);
        hs_next  = ((x_next >= HS_START) && (x_next <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_next  = ((y_next >= VS_START) && (y_next <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        ft_next  = tick_next && (x_next == H_MAX) && (y_next == V_MAX);
    end

    // stage p0: prescaler, counters and decoded outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_p0 <= '0;
            tick_p0  <= 1'b0;
            x_p0     <= '0;
            y_p0     <= '0;
            von_p0   <= 1'b1;
            hs_p0    <= ~SYNC_POL;
            vs_p0    <= ~SYNC_POL;
            ft_p0    <= 1'b0;
        end else begin
            presc_p0 <= presc_next;
            tick_p0  <= tick_next;
            x_p0     <= x_next;
            y_p0     <= y_next;
            von_p0   <= von_next;
            hs_p0    <= hs_next;
            vs_p0    <= vs_next;
            ft_p0    <= ft_next;
        end
    end

    assign vga.pix_x      = x_p0;
    assign vga.pix_y      = y_p0;
    assign vga.video_on   = von_p0;
    assign vga.hsync      = hs_p0;
    assign vga.vsync      = vs_p0;
    assign vga.p_tick     = tick_p0;
    assign vga.frame_tick = ft_p0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Three instances share one clock:
//   dut_a : default 640x480 timing, DIV=4
//   dut_b : reduced 35x19 raster, DIV=4, active-low sync
//   dut_c : reduced 35x19 raster, DIV=1, active-high sync
// A closed-form raster model queues the expected outputs for every clock of every
// instance; scenario tasks add targeted checks on top.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ft;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    vga_sync_gen dut_a (.clk(clk), .reset(rst_a), .vga(if_a));

    vga_sync_gen #(
        .DIV(4), .H_DISP(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_DISP(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) dut_b (.clk(clk), .reset(rst_b), .vga(if_b));

    vga_sync_gen #(
        .DIV(1), .H_DISP(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_DISP(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) dut_c (.clk(clk), .reset(rst_c), .vga(if_c));

    // t = clocks since the last edge that sampled reset high.
    function automatic obs_t model(input int t, input int div,
                                   input int hd, input int hfp, input int hsw, input int hbp,
                                   input int vd, input int vfp, input int vsw, input int vbp,
                                   input bit pol);
        obs_t o;
        int ht, vt, cnt, pos, x, y;
        ht   = hd + hfp + hsw + hbp;
        vt   = vd + vfp + vsw + vbp;
        o.pt = (t >= 1) && ((t % div) == div - 1);
        cnt  = t / div;
        if (div == 1 && t > 0) cnt = t - 1;
        pos  = cnt % (ht * vt);
        x    = pos % ht;
        y    = pos / ht;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.von = (x < hd) && (y < vd);
        o.hs  = (x >= hd + hfp && x < hd + hfp + hsw) ? pol : ~pol;
        o.vs  = (y >= vd + vfp && y < vd + vfp + vsw) ? pol : ~pol;
        o.ft  = o.pt && (x == ht - 1) && (y == vt - 1);
        return o;
    endfunction

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];
    int t_a = 0, t_b = 0, t_c = 0;
    bit live_a = 0, live_b = 0, live_c = 0;

    // Scoreboard producers: push the expected state for the cycle each edge starts.
    initial forever begin
        @(posedge clk);
        if (rst_a) begin t_a = 0; live_a = 1; end else if (live_a) t_a++;
        if (rst_b) begin t_b = 0; live_b = 1; end else if (live_b) t_b++;
        if (rst_c) begin t_c = 0; live_c = 1; end else if (live_c) t_c++;
        if (live_a) q_a.push_back(model(t_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        if (live_b) q_b.push_back(model(t_b, 4, 20, 4, 6, 5, 12, 2, 2, 3, 1'b0));
        if (live_c) q_c.push_back(model(t_c, 1, 20, 4, 6, 5, 12, 2, 2, 3, 1'b1));
    end

    // Scoreboard consumers: compare on the falling edge.
    initial forever begin
        obs_t e, g;
        @(negedge clk);
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            g = '{if_a.pix_x, if_a.pix_y, if_a.video_on, if_a.hsync, if_a.vsync,
                  if_a.p_tick, if_a.frame_tick};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL sb_a t=%0d got=%h expected=%h", t_a, g, e);
            end
        end
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            g = '{if_b.pix_x, if_b.pix_y, if_b.video_on, if_b.hsync, if_b.vsync,
                  if_b.p_tick, if_b.frame_tick};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL sb_b t=%0d got=%h expected=%h", t_b, g, e);
            end
        end
        if (q_c.size() != 0) begin
            e = q_c.pop_front();
            g = '{if_c.pix_x, if_c.pix_y, if_c.video_on, if_c.hsync, if_c.vsync,
                  if_c.p_tick, if_c.frame_tick};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL sb_c t=%0d got=%h expected=%h", t_c, g, e);
            end
        end
    end

    task automatic test_reset();
        obs_t g, e;
        repeat (3) @(negedge clk);
        e = '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        g = '{if_a.pix_x, if_a.pix_y, if_a.video_on, if_a.hsync, if_a.vsync,
              if_a.p_tick, if_a.frame_tick};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL reset_state got=%h expected=%h", g, e);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (if_a.p_tick !== ((k == 3) || (k == 7))) begin
                failures++;
                $display("FAIL first_ptick clk=%0d got=%b expected=%b", k + 1, if_a.p_tick,
                         (k == 3) || (k == 7));
            end
        end
    endtask

    task automatic test_frame();
        bit found = 0;
        int n = 0, vs_min = 1023, vs_max = -1, vs_clks = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (if_b.frame_tick) begin found = 1; break; end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_tick_first got=none expected=pulse within 3000 clks");
            return;
        end
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            if (if_b.vsync == 1'b0) begin
                vs_clks++;
                if (int'(if_b.pix_y) < vs_min) vs_min = int'(if_b.pix_y);
                if (int'(if_b.pix_y) > vs_max) vs_max = int'(if_b.pix_y);
            end
            if (if_b.frame_tick) begin found = 1; break; end
        end
        checks++;
        if (!found || n != 2660) begin
            failures++;
            $display("FAIL frame_spacing got=%0d expected=2660", n);
        end
        checks++;
        if (if_b.pix_x !== 10'd34 || if_b.pix_y !== 10'd18 || if_b.p_tick !== 1'b1) begin
            failures++;
            $display("FAIL frame_tick_pos got=(%0d,%0d,pt=%b) expected=(34,18,pt=1)",
                     if_b.pix_x, if_b.pix_y, if_b.p_tick);
        end
        checks++;
        if (vs_min != 14 || vs_max != 15 || vs_clks != 280) begin
            failures++;
            $display("FAIL vsync_window got=%0d..%0d clks=%0d expected=14..15 clks=280",
                     vs_min, vs_max, vs_clks);
        end
    endtask

    task automatic test_div1();
        bit found = 0;
        int zeros = 0, n = 0, hs_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (if_c.p_tick !== 1'b1) zeros++;
        end
        checks++;
        if (zeros != 0) begin
            failures++;
            $display("FAIL div1_ptick got=%0d low cycles expected=0", zeros);
        end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (if_c.frame_tick) begin found = 1; break; end
        end
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (if_c.hsync === 1'b1) hs_hi++;
            if (if_c.frame_tick) begin found = 1; break; end
        end
        checks++;
        if (!found || n != 665) begin
            failures++;
            $display("FAIL div1_frame got=%0d expected=665", n);
        end
        checks++;
        if (hs_hi != 114) begin
            failures++;
            $display("FAIL div1_hsync_high got=%0d expected=114", hs_hi);
        end
    endtask

    task automatic test_mid_reset();
        obs_t g, e;
        bit found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (if_b.pix_x == 10'd15 && if_b.pix_y == 10'd9 && if_b.p_tick) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_reset_reach got=none expected=(15,9)");
            return;
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        e = '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        g = '{if_b.pix_x, if_b.pix_y, if_b.video_on, if_b.hsync, if_b.vsync,
              if_b.p_tick, if_b.frame_tick};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL mid_reset_state got=%h expected=%h", g, e);
        end
        rst_b = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (if_b.p_tick !== (k == 3)) begin
                failures++;
                $display("FAIL mid_reset_ptick k=%0d got=%b expected=%b", k, if_b.p_tick, k == 3);
            end
        end
    endtask

    task automatic test_line_wrap();
        bit found = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (if_a.pix_x == 10'd799 && if_a.pix_y == 10'd10 && if_a.p_tick) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wrap_reach got=none expected=(799,10)");
            return;
        end
        @(negedge clk);
        checks++;
        if (if_a.pix_x !== 10'd0 || if_a.pix_y !== 10'd11 || if_a.video_on !== 1'b1) begin
            failures++;
            $display("FAIL line_wrap got=(%0d,%0d,von=%b) expected=(0,11,von=1)",
                     if_a.pix_x, if_a.pix_y, if_a.video_on);
        end
    endtask

    task automatic test_hsync_line();
        int low = 0, mn = 1023, mx = -1, fall = -1;
        logic prev;
        prev = if_a.video_on;
        for (int i = 0; i < 3300; i++) begin
            @(negedge clk);
            if (if_a.hsync == 1'b0) begin
                low++;
                if (int'(if_a.pix_x) < mn) mn = int'(if_a.pix_x);
                if (int'(if_a.pix_x) > mx) mx = int'(if_a.pix_x);
            end
            if (prev && !if_a.video_on) fall = int'(if_a.pix_x);
            prev = if_a.video_on;
            if (if_a.pix_x == 10'd799 && if_a.p_tick) break;
        end
        checks++;
        if (low != 384 || mn != 656 || mx != 751) begin
            failures++;
            $display("FAIL hsync_window got=%0d..%0d clks=%0d expected=656..751 clks=384",
                     mn, mx, low);
        end
        checks++;
        if (fall != 640) begin
            failures++;
            $display("FAIL video_on_fall got=%0d expected=640", fall);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_div1();
        test_mid_reset();
        test_line_wrap();
        test_hsync_line();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
